// File: rtl/seven_seg_scan_controller.sv
// Time-multiplexed scanner for a 4-digit common-anode seven-segment display.
// Blanking dead-time between digits, leading-zero suppression, frame-aligned value updates.
module seven_seg_scan_controller #(
    parameter int unsigned ON_CYCLES    = 99000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        load,
    output logic        load_ack,
    input  logic        blank_lz,
    input  logic [3:0]  dp_in,
    output logic [3:0]  hex_out,
    output logic [3:0]  anode,
    output logic        dp_out,
    output logic        frame_done
);

    localparam int unsigned MAX_CYC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         digit_q, digit_d;
    logic [15:0]        shown_q, shown_d;
    logic [15:0]        pend_q, pend_d;
    logic               pend_valid_q, pend_valid_d;
    logic [3:0]         hex_q, hex_d;
    logic [3:0]         anode_q, anode_d;
    logic               dp_q, dp_d;
    logic               fd_q, fd_d;
    logic               ack_q, ack_d;
    logic               boundary_c;
    logic               lz_c;

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            digit_q      <= 2'd0;
            shown_q      <= 16'h0000;
            pend_q       <= 16'h0000;
            pend_valid_q <= 1'b0;
            hex_q        <= 4'h0;
            anode_q      <= 4'b1111;
            dp_q         <= 1'b1;
            fd_q         <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            shown_q      <= shown_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            hex_q        <= hex_d;
            anode_q      <= anode_d;
            dp_q         <= dp_d;
            fd_q         <= fd_d;
            ack_q        <= ack_d;
        end
    end

    // Outputs are computed from next-state so they line up with the state they describe
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        digit_d      = digit_q;
        shown_d      = shown_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        boundary_c   = 1'b0;
        fd_d         = 1'b0;
        ack_d        = 1'b0;
        anode_d      = 4'b1111;
        dp_d         = 1'b1;
        lz_c         = 1'b0;

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                end
            end
            ST_ON: begin
                if (cnt_q == CNT_W'(ON_CYCLES - 1)) begin
                    state_d    = ST_BLANK;
                    cnt_d      = '0;
                    digit_d    = digit_q + 2'd1;
                    boundary_c = (digit_q == 2'd3);
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase

        // Old pending is promoted before a same-cycle load overwrites it
        if (boundary_c) begin
            fd_d = 1'b1;
            if (pend_valid_q) begin
                shown_d      = pend_q;
                pend_valid_d = 1'b0;
                ack_d        = 1'b1;
            end
        end
        if (load) begin
            pend_d       = value;
            pend_valid_d = 1'b1;
        end

        hex_d = shown_d[{digit_d, 2'b00} +: 4];
        lz_c  = blank_lz && (digit_d != 2'd0) && ((shown_d >> {digit_d, 2'b00}) == 16'h0000);

        if ((state_d == ST_ON) && !lz_c) begin
            anode_d = ~(4'b0001 << digit_d);
            dp_d    = ~dp_in[digit_d];
        end
    end

    assign hex_out    = hex_q;
    assign anode      = anode_q;
    assign dp_out     = dp_q;
    assign frame_done = fd_q;
    assign load_ack   = ack_q;

endmodule
